board_scanner: RTL and testbench
================================

BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 Parameter BOARD_X0, default 10'd240: screen X of board left edge.
REQ-002 Parameter BOARD_Y0, default 10'd80: screen Y of board top edge.
REQ-003 Parameter CURTAIN_DIV, default 4: frames per game-over curtain row step (range 1..15).
REQ-004 Clk  in  1  system clock; all state on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 DrawX  in  10  current scan pixel X.
REQ-007 DrawY  in  10  current scan pixel Y.
REQ-008 frame_tick  in  1  one-cycle pulse once per frame (vsync start).
REQ-009 gameover_req  in  1  level; game logic declares game over.
REQ-010 restart  in  1  one-cycle pulse; clears curtain.
REQ-011 board_addr  out  8  board RAM read address, row*10+col (0..199).
REQ-012 board_data  in  2  board RAM read data, valid one cycle after board_addr.
REQ-013 block_template  out  2  template code for block_memory (11 = empty/black).
REQ-014 pixel_x  out  4  column within 16x16 block.
REQ-015 pixel_y  out  4  row within 16x16 block.
REQ-016 gameover  out  1  per-pixel curtain override for block_memory.
REQ-017 in_board  out  1  current output pixel lies inside the 160x320 board.
REQ-018 curtain_done  out  1  curtain fully drawn.

Function
REQ-019 Board is 10 columns x 20 rows of 16x16 pixels; area X in [BOARD_X0, BOARD_X0+159], Y in [BOARD_Y0, BOARD_Y0+319], edges inclusive.
REQ-020 Stage 1: register dx=DrawX-BOARD_X0, dy=DrawY-BOARD_Y0, inside flag; board_addr registered = dy[8:4]*10 + dx[7:4]; board_addr held 0 when outside.
REQ-021 Stage 2: register pixel_x=dx[3:0], pixel_y=dy[3:0], row=dy[8:4], inside; board_data sampled this cycle.
REQ-022 All outputs correspond to DrawX/DrawY sampled exactly 2 rising edges earlier; fixed latency, no stalls.
REQ-023 Outside board: in_board=0, block_template=2'b11, gameover=0, pixel_x/pixel_y still driven from dx/dy low bits.
REQ-024 Inside board: block_template=board_data, in_board=1.
REQ-025 Curtain FSM states IDLE, FILL, DONE; curtain_row counter 5 bits, frame divider 4 bits.
REQ-026 IDLE: gameover_req=1 -> FILL, curtain_row=0, divider=0.
REQ-027 FILL: each frame_tick increments divider; when divider reaches CURTAIN_DIV-1 with frame_tick, divider=0 and curtain_row+1; frame_tick on curtain_row=19 at terminal count -> DONE.
REQ-028 DONE: holds; curtain_done=1 only in DONE.
REQ-029 restart in FILL or DONE -> IDLE, counters 0; restart wins over simultaneous frame_tick; restart in IDLE with gameover_req=1 stays IDLE that cycle.
REQ-030 Per-pixel gameover=1 iff in_board and (state=DONE or (state=FILL and row<=curtain_row)); row is stage-2 row.
REQ-031 gameover_req deassert during FILL has no effect; only restart leaves FILL/DONE.
REQ-032 Subtractions width 10 bits; negative results (DrawX<BOARD_X0) flagged outside via compare, not by wrap.

Reset
REQ-033 Reset_n low asynchronously: state=IDLE, curtain_row=0, divider=0, pipeline regs 0, inside=0.
REQ-034 Outputs in reset: board_addr=0, block_template=2'b11, pixel_x=0, pixel_y=0, gameover=0, in_board=0, curtain_done=0.
REQ-035 Reset mid-FILL abandons curtain; first valid output 2 edges after release.

Structure
REQ-036 Shared package tetris_pkg holds BOARD_COLS=10, BOARD_ROWS=20, BLOCK_PX=16, template code enum (WHITE, LIGHT, DARK, EMPTY=2'b11), curtain state enum.
REQ-037 One sub-module curtain_fsm (states, divider, curtain_row, curtain_done); pixel pipeline in top.

Verification
REQ-038 DrawX=240, DrawY=80 -> after 2 edges board_addr issued 0, outputs pixel_x=0, pixel_y=0, in_board=1, block_template=board_data.
REQ-039 DrawX=399, DrawY=399 -> board_addr=199, pixel_x=15, pixel_y=15, in_board=1; DrawX=400 -> in_board=0, template=11.
REQ-040 DrawX=239 (and DrawX=0,DrawY=0) -> in_board=0, gameover=0 even in DONE.
REQ-041 gameover_req=1, CURTAIN_DIV=4, 80 frame_ticks -> curtain_row steps every 4 ticks, DONE after 80th tick, curtain_done=1; pixel at row 5 gameover=1 once curtain_row>=5.
REQ-042 restart coincident with frame_tick in FILL -> IDLE next edge, curtain_row=0, gameover=0.
REQ-043 Reset_n pulse low mid-FILL -> all outputs to reset values immediately, IDLE after release.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry, template codes and curtain state encoding.
// Pure declarations; no timing of its own.
// Imported by the board scanner top and the curtain sequencer.
package tetris_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int BLOCK_PX   = 16;
  localparam int BOARD_W    = BOARD_COLS * BLOCK_PX;  // 160 pixels
  localparam int BOARD_H    = BOARD_ROWS * BLOCK_PX;  // 320 pixels

  // Template code handed to block_memory; EMPTY renders black.
  typedef enum logic [1:0] {
    TPL_WHITE = 2'b00,
    TPL_LIGHT = 2'b01,
    TPL_DARK  = 2'b10,
    TPL_EMPTY = 2'b11
  } template_e;

  // Game-over curtain sequencer states.
  typedef enum logic [1:0] {
    CUR_IDLE = 2'b00,
    CUR_FILL = 2'b01,
    CUR_DONE = 2'b10
  } curtain_state_e;

  // Linear board RAM address of a cell: row*10 + col, built from shifts.
  function automatic logic [7:0] cell_addr(input logic [4:0] row, input logic [3:0] col);
    return {row, 3'b000} + {2'b00, row, 1'b0} + {4'b0000, col};
  endfunction

endpackage

// File: rtl/board_scanner_curtain_fsm.sv
// Game-over curtain sequencer: lowers the curtain one block row per CURTAIN_DIV frames.
// Latency: state and counters update on the rising edge after the qualifying input.
// No backpressure; restart always wins and returns to IDLE with counters cleared.
module curtain_fsm
  import tetris_pkg::*;
#(
  parameter int CURTAIN_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_gameover_req,
  input  logic       i_restart,
  output logic [1:0] o_state,
  output logic [4:0] o_curtain_row,
  output logic       o_curtain_done
);

  localparam logic [3:0] LAST_DIV = 4'(CURTAIN_DIV - 1);
  localparam logic [4:0] LAST_ROW = 5'(BOARD_ROWS - 1);

  curtain_state_e r_state;
  curtain_state_e w_state_nxt;
  logic [4:0]     r_row;
  logic [4:0]     w_row_nxt;
  logic [3:0]     r_div;
  logic [3:0]     w_div_nxt;

  // State and counter registers; reset abandons any curtain in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CUR_IDLE;
      r_row   <= 5'd0;
      r_div   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_div   <= w_div_nxt;
    end
  end

  // Next-state logic: start on request, step rows on divided frame ticks, restart clears.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_div_nxt   = r_div;
    case (r_state)
      CUR_IDLE: begin
        // A restart pulse in the same cycle as the request keeps us idle for that cycle.
        if (!i_restart && i_gameover_req) begin
          w_state_nxt = CUR_FILL;
          w_row_nxt   = 5'd0;
          w_div_nxt   = 4'd0;
        end
      end
      CUR_FILL: begin
        if (i_restart) begin
          w_state_nxt = CUR_IDLE;
          w_row_nxt   = 5'd0;
          w_div_nxt   = 4'd0;
        end else if (i_frame_tick) begin
          if (r_div == LAST_DIV) begin
            w_div_nxt = 4'd0;
            // Bottom row already covered: the curtain is complete, row stays put.
            if (r_row == LAST_ROW) begin
              w_state_nxt = CUR_DONE;
            end else begin
              w_row_nxt = r_row + 5'd1;
            end
          end else begin
            w_div_nxt = r_div + 4'd1;
          end
        end
      end
      CUR_DONE: begin
        if (i_restart) begin
          w_state_nxt = CUR_IDLE;
          w_row_nxt   = 5'd0;
          w_div_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = CUR_IDLE;
        w_row_nxt   = 5'd0;
        w_div_nxt   = 4'd0;
      end
    endcase
  end

  assign o_state        = r_state;
  assign o_curtain_row  = r_row;
  assign o_curtain_done = (r_state == CUR_DONE);

endmodule

// File: rtl/board_scanner.sv
// Maps the scan position onto the 10x20 Tetris board, fetches cell data and applies the curtain.
// Latency: every output reflects DrawX/DrawY from exactly 2 rising edges earlier.
// Free-running pipeline with no stalls; board RAM must answer one cycle after board_addr.
module board_scanner
  import tetris_pkg::*;
#(
  parameter logic [9:0] BOARD_X0    = 10'd240,
  parameter logic [9:0] BOARD_Y0    = 10'd80,
  parameter int         CURTAIN_DIV = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       frame_tick,
  input  logic       gameover_req,
  input  logic       restart,
  output logic [7:0] board_addr,
  input  logic [1:0] board_data,
  output logic [1:0] block_template,
  output logic [3:0] pixel_x,
  output logic [3:0] pixel_y,
  output logic       gameover,
  output logic       in_board,
  output logic       curtain_done
);

  // Inclusive far edges, widened so a board placed near the screen edge cannot wrap.
  localparam logic [10:0] X_LAST = {1'b0, BOARD_X0} + 11'(BOARD_W - 1);
  localparam logic [10:0] Y_LAST = {1'b0, BOARD_Y0} + 11'(BOARD_H - 1);

  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic       w_inside;
  logic       w_unused_hi;
  logic [1:0] w_state;
  logic [4:0] w_curtain_row;

  // Stage 1 registers
  logic [3:0] r_dx_lo1;
  logic [3:0] r_dy_lo1;
  logic [4:0] r_row1;
  logic       r_inside1;
  logic [7:0] r_addr;

  // Stage 2 registers
  logic [3:0] r_pix_x;
  logic [3:0] r_pix_y;
  logic [4:0] r_row2;
  logic       r_inside2;
  logic [1:0] r_data;

  // Board-relative offsets; below-origin positions wrap here but are rejected by the compares.
  assign w_dx = DrawX - BOARD_X0;
  assign w_dy = DrawY - BOARD_Y0;

  assign w_inside = (DrawX >= BOARD_X0) && ({1'b0, DrawX} <= X_LAST) &&
                    (DrawY >= BOARD_Y0) && ({1'b0, DrawY} <= Y_LAST);

  // Offset bits beyond the board extent are never needed once inside is known.
  assign w_unused_hi = ^{w_dx[9:8], w_dy[9]};

  // Stage 1: capture offsets and issue the cell address (parked at 0 off-board).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_dx_lo1  <= 4'd0;
      r_dy_lo1  <= 4'd0;
      r_row1    <= 5'd0;
      r_inside1 <= 1'b0;
      r_addr    <= 8'd0;
    end else begin
      r_dx_lo1  <= w_dx[3:0];
      r_dy_lo1  <= w_dy[3:0];
      r_row1    <= w_dy[8:4];
      r_inside1 <= w_inside;
      r_addr    <= w_inside ? cell_addr(w_dy[8:4], w_dx[7:4]) : 8'd0;
    end
  end

  // Stage 2: align pixel coordinates and row with the RAM data returned for stage 1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pix_x   <= 4'd0;
      r_pix_y   <= 4'd0;
      r_row2    <= 5'd0;
      r_inside2 <= 1'b0;
      r_data    <= 2'b00;
    end else begin
      r_pix_x   <= r_dx_lo1;
      r_pix_y   <= r_dy_lo1;
      r_row2    <= r_row1;
      r_inside2 <= r_inside1;
      r_data    <= board_data;
    end
  end

  curtain_fsm #(
    .CURTAIN_DIV (CURTAIN_DIV)
  ) u_curtain (
    .i_clk          (Clk),
    .i_rst_n        (Reset_n),
    .i_frame_tick   (frame_tick),
    .i_gameover_req (gameover_req),
    .i_restart      (restart),
    .o_state        (w_state),
    .o_curtain_row  (w_curtain_row),
    .o_curtain_done (curtain_done)
  );

  assign board_addr     = r_addr;
  assign pixel_x        = r_pix_x;
  assign pixel_y        = r_pix_y;
  assign in_board       = r_inside2;
  assign block_template = r_inside2 ? r_data : TPL_EMPTY;

  // Curtain covers every row up to and including the current curtain row, or all once done.
  assign gameover = r_inside2 &&
                    ((w_state == CUR_DONE) ||
                     ((w_state == CUR_FILL) && (r_row2 <= w_curtain_row)));

endmodule

// File: tb/tb_board_scanner.sv
// Directed plus randomized bench for board_scanner against a behavioural pixel/curtain model.
module tb_board_scanner;

  localparam int X0  = 240;
  localparam int Y0  = 80;
  localparam int DIV = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [9:0] DrawX, DrawY;
  logic       frame_tick, gameover_req, restart;
  logic [7:0] board_addr;
  logic [1:0] board_data;
  logic [1:0] block_template;
  logic [3:0] pixel_x, pixel_y;
  logic       gameover, in_board, curtain_done;

  logic [1:0] mem [200];

  int checks = 0;
  int fails  = 0;

  // Model: two-deep history of the expected per-pixel results.
  int m1_in, m1_px, m1_py, m1_row, m1_addr;
  int m2_in, m2_px, m2_py, m2_row, m2_addr;
  // Curtain model: 0 idle, 1 filling, 2 done; ticks counted since fill start.
  int m_mode, m_ticks;

  always #5 Clk = ~Clk;

  assign board_data = (board_addr < 8'd200) ? mem[board_addr] : 2'b00;

  board_scanner #(
    .BOARD_X0    (10'd240),
    .BOARD_Y0    (10'd80),
    .CURTAIN_DIV (DIV)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .frame_tick     (frame_tick),
    .gameover_req   (gameover_req),
    .restart        (restart),
    .board_addr     (board_addr),
    .board_data     (board_data),
    .block_template (block_template),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .gameover       (gameover),
    .in_board       (in_board),
    .curtain_done   (curtain_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m1_in = 0; m1_px = 0; m1_py = 0; m1_row = 0; m1_addr = 0;
    m2_in = 0; m2_px = 0; m2_py = 0; m2_row = 0; m2_addr = 0;
    m_mode = 0; m_ticks = 0;
  endtask

  task automatic model_edge(input int x, input int y, input bit ft, input bit gr, input bit rs);
    m2_in = m1_in; m2_px = m1_px; m2_py = m1_py; m2_row = m1_row; m2_addr = m1_addr;
    m1_in  = (x >= X0 && x < X0 + 160 && y >= Y0 && y < Y0 + 320) ? 1 : 0;
    m1_px  = (x - X0) & 15;
    m1_py  = (y - Y0) & 15;
    m1_row = ((y - Y0) & 511) / 16;
    m1_addr = m1_in ? ((y - Y0) / 16) * 10 + (x - X0) / 16 : 0;
    if (m_mode == 0) begin
      if (!rs && gr) begin m_mode = 1; m_ticks = 0; end
    end else if (rs) begin
      m_mode = 0; m_ticks = 0;
    end else if (m_mode == 1 && ft) begin
      m_ticks++;
      if (m_ticks == 20 * DIV) m_mode = 2;
    end
  endtask

  task automatic check_all();
    int exp_go;
    exp_go = (m2_in != 0 && (m_mode == 2 || (m_mode == 1 && m2_row <= m_ticks / DIV))) ? 1 : 0;
    chk("board_addr",     32'(board_addr),     32'(m1_addr));
    chk("pixel_x",        32'(pixel_x),        32'(m2_px));
    chk("pixel_y",        32'(pixel_y),        32'(m2_py));
    chk("in_board",       32'(in_board),       32'(m2_in));
    chk("block_template", 32'(block_template), m2_in != 0 ? 32'(mem[m2_addr]) : 32'd3);
    chk("gameover",       32'(gameover),       32'(exp_go));
    chk("curtain_done",   32'(curtain_done),   (m_mode == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input int x, input int y, input bit ft, input bit gr, input bit rs);
    DrawX = 10'(x); DrawY = 10'(y);
    frame_tick = ft; gameover_req = gr; restart = rs;
    @(posedge Clk);
    if (Reset_n) model_edge(x, y, ft, gr, rs);
    else model_reset();
    #1 check_all();
  endtask

  task automatic pick(output int x, output int y);
    int xe [4];
    int ye [4];
    xe = '{239, 240, 399, 400};
    ye = '{79, 80, 399, 400};
    case ($urandom_range(0, 4))
      0: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
      1: begin x = xe[$urandom_range(0, 3)]; y = ye[$urandom_range(0, 3)]; end
      2: begin x = $urandom_range(240, 399); y = 160 + $urandom_range(0, 15); end
      default: begin x = $urandom_range(220, 420); y = $urandom_range(60, 420); end
    endcase
  endtask

  task automatic fill_ticks(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        pick(x, y);
        step(x, y, 0, 0, 0);
      end
      pick(x, y);
      step(x, y, 1, 0, 0);
    end
  endtask

  initial begin
    int x, y;
    for (int i = 0; i < 200; i++) mem[i] = 2'($urandom_range(0, 3));
    Reset_n = 1'b0;
    DrawX = 10'd240; DrawY = 10'd80;
    frame_tick = 0; gameover_req = 1; restart = 0;
    model_reset();
    #1 check_all();
    step(240, 80, 1, 1, 0);
    @(negedge Clk) Reset_n = 1'b1;

    // Corners, edges and far-off positions through the pipeline.
    step(240, 80, 0, 0, 0);
    step(399, 399, 0, 0, 0);
    step(400, 399, 0, 0, 0);
    step(239, 100, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(300, 160, 0, 0, 0);
    step(300, 160, 0, 0, 0);

    // Full curtain: one request, then 80 ticks with random gaps.
    step(300, 160, 0, 1, 0);
    step(300, 160, 0, 0, 0);
    fill_ticks(80);
    step(239, 200, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(300, 399, 0, 0, 0);
    step(300, 399, 0, 0, 0);

    // Restart from DONE, then restart racing a new request in IDLE.
    step(300, 200, 0, 0, 1);
    step(300, 200, 0, 1, 1);
    step(300, 200, 0, 1, 0);
    fill_ticks(9);
    step(300, 100, 1, 0, 1);
    step(300, 100, 0, 0, 0);
    step(300, 100, 0, 0, 0);

    // Reset pulse in the middle of a curtain fill.
    step(300, 100, 0, 1, 0);
    fill_ticks(13);
    #2 Reset_n = 1'b0;
    #1 model_reset();
    check_all();
    step(300, 100, 1, 0, 0);
    @(negedge Clk) Reset_n = 1'b1;
    step(300, 100, 0, 0, 0);
    step(300, 100, 0, 0, 0);
    step(300, 100, 1, 0, 0);

    // Free-running random traffic on every input.
    for (int i = 0; i < 600; i++) begin
      pick(x, y);
      step(x, y, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 60) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
